program_feeder: RTL and testbench
=================================

# program_feeder

Instruction sequencer that sits directly upstream of the processor. It holds a small program in internal RAM and drives the processor's `DIN`/`Run` inputs. It waits on the processor's `Done` before issuing the next instruction. For `mvi` it supplies the following immediate word on `DIN`, and it stops on a halt opcode.

## Interface
- `ADDR_W`, 5: program RAM address width (2^ADDR_W words of 16 bits).
- `MVI_OP`, 3'b001: opcode in bits [8:6] that takes an immediate word.
- `HALT_OP`, 3'b111: opcode in bits [8:6] that stops the feeder; it is never issued to the processor.

Ports:
- `clk`  in  1  single clock, rising edge.
- `Reset`  in  1  synchronous, active-low reset.
- `Start`  in  1  begin execution at address 0; honoured only in IDLE or HALTED.
- `Load_we`  in  1  program RAM write enable; honoured only in IDLE or HALTED.
- `Load_adr`  in  ADDR_W  program RAM write address.
- `Load_data`  in  16  program RAM write data.
- `Done`  in  1  processor instruction-complete strobe.
- `DIN`  out  16  word presented to the processor.
- `Run`  out  1  one-cycle instruction-issue strobe to the processor.
- `PC`  out  ADDR_W  address of the current instruction.
- `Busy`  out  1  high in FETCH, ISSUE and WAIT.
- `Halted`  out  1  high in HALTED.
- `Instr_count`  out  8  number of instructions completed since Start; saturates at 255.

## Operation
- Program RAM:
  - Writes are synchronous.
  - Reads are synchronous: the address is presented in one cycle and the data is valid the next.
  - RAM contents are not cleared by reset.
- States: IDLE, FETCH, ISSUE, WAIT, HALTED.
- IDLE / HALTED:
  - `DIN`=0, `Run`=0.
  - `Load_we` writes the RAM.
  - On `Start`: PC←0, `Instr_count`←0, go to FETCH.
  - If `Start` and `Load_we` occur in the same cycle, the write completes and Start is still taken.
- FETCH:
  - Read RAM[PC] and latch it into the instruction register (IR).
  - Go to ISSUE.
- ISSUE:
  - If IR[8:6]==HALT_OP: `Run` stays 0, go to HALTED. PC holds the halt address.
  - Otherwise: `DIN`=IR and `Run`=1 for this single cycle.
  - If IR[8:6]==MVI_OP, read RAM[(PC+1) mod 2^ADDR_W] into the immediate register in this cycle.
  - Go to WAIT.
- WAIT:
  - `Run`=0.
  - `DIN` = immediate register if the instruction was MVI, otherwise IR. It is held stable until `Done`.
  - On `Done`=1:
    - PC ← PC+2 for MVI, PC+1 otherwise, modulo 2^ADDR_W (wrap, no error).
    - `Instr_count` increments (saturating).
    - Go to FETCH.
- `Done` in any state other than WAIT is ignored.
- `Start` while Busy is ignored.
- `Load_we` while Busy is ignored; the RAM is unchanged.
- With no `Done`, WAIT persists indefinitely; there is no timeout.
- Reset low at any clock edge, including mid-instruction:
  - State IDLE; PC=0, `DIN`=0, `Run`=0, `Busy`=0, `Halted`=0, `Instr_count`=0.
  - Reset overrides `Start` and `Load_we` in the same cycle.

## Timing
- Start taken at edge N:
  - FETCH during cycle N+1.
  - ISSUE (`Run`=1) during cycle N+2.
  - WAIT from cycle N+3.
- `Done` sampled high at edge M (in WAIT):
  - PC is updated after edge M.
  - FETCH in cycle M+1; the next `Run` is in cycle M+2.
- Minimum issue-to-issue spacing is 3 cycles plus the processor latency.
- The MVI immediate is on `DIN` from the first WAIT cycle (cycle after `Run`) until `Done`.
- Halt: ISSUE cycle, then `Halted`=1 from the following cycle; `Busy` drops in the same cycle.
- `Run` is never high for two consecutive cycles.
- All outputs are registered or decoded from registered state; there is no combinational path from `Done` to `DIN`/`Run`.

## Test plan
- Reset, then idle: all outputs 0 and no `Run` for 20 cycles, even with `Done` toggling.
- Load program, single non-MVI instruction then halt:
  - Program: RAM[0]=16'h0008 (mv), RAM[1]=16'h01C0 (halt). Pulse `Start`; `Done` 3 cycles after `Run`.
  - Exactly one `Run` with `DIN`=0008.
  - `Halted`=1, PC=1, `Instr_count`=1.
- MVI with immediate:
  - Program: RAM[0]=16'h0040, RAM[1]=16'h1234, RAM[2]=halt.
  - `Run` with `DIN`=0040, then `DIN`=1234 held until `Done`.
  - Next fetch at PC=2, then halt.
- Wrap-around:
  - Program: MVI at address 31, immediate expected from RAM[0]; RAM[1]=halt.
  - `DIN`=RAM[0] during WAIT; PC wraps to 1; halts.
- Ignored inputs while Busy: `Start` and `Load_we` (adr 0, data FFFF) pulsed during WAIT → no restart; RAM[0] unchanged on re-run.
- Reset mid-WAIT, then recovery:
  - Reset mid-WAIT → next cycle IDLE, `Run`=0, `DIN`=0, `Instr_count`=0.
  - A subsequent `Start` reruns the program from address 0.

Source files
------------

// File: rtl/program_feeder.sv
// program_feeder: instruction sequencer placed directly in front of the processor.
// A 2^ADDR_W x 16 program RAM is loaded while the feeder is IDLE or HALTED.
// After Start, each instruction is fetched into IR and issued with a single-cycle
// Run strobe. The feeder then waits for Done before fetching the next instruction.
// For MVI, the word after the instruction is read into an immediate register.
// That word is held on DIN for the whole wait. A HALT opcode is never issued;
// it parks the feeder in HALTED.
//
// Handshake: Run is a one-cycle issue strobe and DIN is valid from the Run cycle
// until Done is sampled high in WAIT. Done is honoured only in WAIT. Start and
// Load_we are honoured only in IDLE/HALTED. The feeder never re-issues before the
// previous instruction has reported Done.
module program_feeder #(
    parameter int         ADDR_W  = 5,
    parameter logic [2:0] MVI_OP  = 3'b001,
    parameter logic [2:0] HALT_OP = 3'b111
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Load_we,
    input  logic [ADDR_W-1:0] Load_adr,
    input  logic [15:0]       Load_data,
    input  logic              Done,
    output logic [15:0]       DIN,
    output logic              Run,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              Halted,
    output logic [7:0]        Instr_count,
    output logic [2:0]        dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [15:0]       imm_q, imm_d;
    logic [7:0]        cnt_q, cnt_d;

    logic [15:0]       mem [DEPTH];

    logic              loadable;
    logic              ram_we;
    logic              ir_is_mvi;
    logic              ir_is_halt;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] pc_plus2;

    // Loading is only allowed while parked. Reset low blocks the write, so reset
    // wins over Load_we in the same cycle.
    assign loadable   = (state_q == S_IDLE) || (state_q == S_HALTED);
    assign ram_we     = Reset && Load_we && loadable;

    assign ir_is_mvi  = (ir_q[8:6] == MVI_OP);
    assign ir_is_halt = (ir_q[8:6] == HALT_OP);

    // The address arithmetic wraps naturally at 2^ADDR_W.
    assign pc_plus1   = pc_q + 1'b1;
    assign pc_plus2   = pc_q + ADDR_W'(2);

    // Program RAM write port: a plain synchronous write; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[Load_adr] <= Load_data;
        end
    end

    // FSM state register. A synchronous active-low reset returns the FSM to IDLE.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (Start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = ir_is_halt ? S_HALTED : S_WAIT;
            end
            S_WAIT: begin
                if (Done) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next values: PC and count update, plus the RAM read registers.
    // The IR and immediate registers are only loaded in their own state, so each
    // read is an address-in-one-cycle, data-next-cycle access.
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        ir_d  = ir_q;
        imm_d = imm_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (Start) begin
                    pc_d  = '0;
                    cnt_d = '0;
                end
            end
            S_FETCH: begin
                ir_d = mem[pc_q];
            end
            S_ISSUE: begin
                if (ir_is_mvi) begin
                    imm_d = mem[pc_plus1];
                end
            end
            S_WAIT: begin
                if (Done) begin
                    pc_d = ir_is_mvi ? pc_plus2 : pc_plus1;
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // Datapath registers. IR and immediate are also cleared so DIN is never X.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            pc_q  <= '0;
            cnt_q <= '0;
            ir_q  <= '0;
            imm_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            ir_q  <= ir_d;
            imm_q <= imm_d;
        end
    end

    // FSM outputs are decoded from registered state only, so Done has no
    // combinational path to DIN or Run.
    always_comb begin
        DIN    = '0;
        Run    = 1'b0;
        Busy   = 1'b0;
        Halted = 1'b0;
        case (state_q)
            S_FETCH: begin
                Busy = 1'b1;
            end
            S_ISSUE: begin
                Busy = 1'b1;
                if (!ir_is_halt) begin
                    Run = 1'b1;
                    DIN = ir_q;
                end
            end
            S_WAIT: begin
                Busy = 1'b1;
                DIN  = ir_is_mvi ? imm_q : ir_q;
            end
            S_HALTED: begin
                Halted = 1'b1;
            end
            default: begin
                DIN = '0;
            end
        endcase
    end

    assign PC          = pc_q;
    assign Instr_count = cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_program_feeder.sv
// tb_program_feeder: directed and randomized checks of program_feeder.
// A behavioural interpreter walks the program image held by the bench. It
// produces the expected issue stream, the expected wait-phase DIN and the final
// PC and count. The bench plays the processor and answers Done after a chosen
// latency.
module tb_program_feeder;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              Reset;
    logic              Start;
    logic              Load_we;
    logic [ADDR_W-1:0] Load_adr;
    logic [15:0]       Load_data;
    logic              Done;
    logic [15:0]       DIN;
    logic              Run;
    logic [ADDR_W-1:0] PC;
    logic              Busy;
    logic              Halted;
    logic [7:0]        Instr_count;
    logic [2:0]        dbg_state;

    int test_cnt = 0;
    int fail_cnt = 0;

    logic [15:0]       tb_mem [DEPTH];
    logic [15:0]       exp_run_q[$];
    logic [15:0]       exp_wait_q[$];
    logic [ADDR_W-1:0] exp_pc_q[$];
    logic [ADDR_W-1:0] exp_end_pc;
    logic              exp_halts;
    int                exp_n;

    // Clock and DUT
    always #5 clk = ~clk;

    program_feeder #(
        .ADDR_W (ADDR_W),
        .MVI_OP (3'b001),
        .HALT_OP(3'b111)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .Start      (Start),
        .Load_we    (Load_we),
        .Load_adr   (Load_adr),
        .Load_data  (Load_data),
        .Done       (Done),
        .DIN        (DIN),
        .Run        (Run),
        .PC         (PC),
        .Busy       (Busy),
        .Halted     (Halted),
        .Instr_count(Instr_count),
        .dbg_state  (dbg_state)
    );

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [ADDR_W-1:0] adr, input logic [15:0] data);
        Load_we   = 1'b1;
        Load_adr  = adr;
        Load_data = data;
        tick();
        Load_we   = 1'b0;
        tb_mem[adr] = data;
    endtask

    function automatic logic [15:0] rand_instr(input logic [2:0] op);
        logic [15:0] w;
        w      = 16'($urandom);
        w[8:6] = op;
        return w;
    endfunction

    // Reference interpreter: run the program image until HALT or max_instr
    // instructions. It records what the processor should observe.
    task automatic build_model(input int max_instr);
        logic [ADDR_W-1:0] pc;
        logic [15:0]       ir;
        logic              mvi;
        exp_run_q.delete();
        exp_wait_q.delete();
        exp_pc_q.delete();
        pc        = '0;
        exp_n     = 0;
        exp_halts = 1'b0;
        while (exp_n < max_instr) begin
            ir = tb_mem[pc];
            if (ir[8:6] == 3'b111) begin
                exp_halts = 1'b1;
                break;
            end
            mvi = (ir[8:6] == 3'b001);
            exp_pc_q.push_back(pc);
            exp_run_q.push_back(ir);
            exp_wait_q.push_back(mvi ? tb_mem[(int'(pc) + 1) % DEPTH] : ir);
            pc = ADDR_W'((int'(pc) + (mvi ? 2 : 1)) % DEPTH);
            exp_n++;
        end
        exp_end_pc = pc;
    endtask

    // Start the program and act as the processor, answering Done after lat (>=1)
    // WAIT cycles. With disturb set, Start and a Load_we to address 0 are pulsed
    // during the first wait; this needs lat >= 2.
    task automatic run_program(input int lat, input bit disturb, input int max_instr);
        int sat;
        build_model(max_instr);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("fetch0_busy", Busy, 1);
        chk("fetch0_run", Run, 0);
        for (int i = 0; i < exp_n; i++) begin
            tick();
            chk("issue_run", Run, 1);
            chk("issue_din", DIN, exp_run_q[i]);
            chk("issue_pc", PC, exp_pc_q[i]);
            for (int k = 0; k < lat; k++) begin
                tick();
                chk("wait_run", Run, 0);
                chk("wait_din", DIN, exp_wait_q[i]);
                chk("wait_busy", Busy, 1);
                chk("wait_pc", PC, exp_pc_q[i]);
                if (disturb && i == 0 && k == 0) begin
                    Start     = 1'b1;
                    Load_we   = 1'b1;
                    Load_adr  = '0;
                    Load_data = 16'hFFFF;
                end else begin
                    Start   = 1'b0;
                    Load_we = 1'b0;
                end
            end
            Start   = 1'b0;
            Load_we = 1'b0;
            Done    = 1'b1;
            tick();
            Done = 1'b0;
            sat  = (i + 1 > 255) ? 255 : i + 1;
            chk("fetch_run", Run, 0);
            chk("fetch_busy", Busy, 1);
            chk("fetch_cnt", Instr_count, sat);
            chk("fetch_pc", PC, (i + 1 < exp_n) ? exp_pc_q[i + 1] : exp_end_pc);
        end
        if (exp_halts) begin
            tick();
            chk("halt_issue_run", Run, 0);
            chk("halt_issue_busy", Busy, 1);
            chk("halt_issue_pc", PC, exp_end_pc);
            tick();
            chk("halted", Halted, 1);
            chk("halted_busy", Busy, 0);
            chk("halted_run", Run, 0);
            chk("halted_din", DIN, 0);
            chk("halted_pc", PC, exp_end_pc);
            chk("halted_cnt", Instr_count, (exp_n > 255) ? 255 : exp_n);
        end
    endtask

    task automatic load_random_program();
        logic [ADDR_W-1:0] addr;
        logic [2:0]        op;
        int                n;
        addr = '0;
        n    = $urandom_range(2, 10);
        for (int k = 0; k < n; k++) begin
            op = 3'($urandom_range(0, 6));
            load_word(addr, rand_instr(op));
            addr++;
            if (op == 3'b001) begin
                load_word(addr, 16'($urandom));
                addr++;
            end
        end
        load_word(addr, rand_instr(3'b111));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_run"}, Run, 0);
        chk({tag, "_din"}, DIN, 0);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_halted"}, Halted, 0);
        chk({tag, "_pc"}, PC, 0);
        chk({tag, "_cnt"}, Instr_count, 0);
    endtask

    // Directed sequence
    initial begin
        Reset     = 1'b0;
        Start     = 1'b0;
        Load_we   = 1'b0;
        Load_adr  = '0;
        Load_data = '0;
        Done      = 1'b0;
        tick();
        tick();
        chk_idle("reset");
        Reset = 1'b1;

        // Idle for 20 cycles with Done toggling: nothing must happen.
        for (int c = 0; c < 20; c++) begin
            Done = 1'($urandom_range(0, 1));
            tick();
            chk_idle("idle");
        end
        Done = 1'b0;

        // Single mv then halt, Done three cycles after Run.
        load_word(5'd0, 16'h0008);
        load_word(5'd1, 16'h01C0);
        run_program(3, 1'b0, 300);

        // MVI with immediate, restarted from HALTED.
        load_word(5'd0, 16'h0040);
        load_word(5'd1, 16'h1234);
        load_word(5'd2, 16'h01C0);
        run_program(2, 1'b0, 300);

        // Wrap-around: MVI at 31 takes its immediate from address 0 and wraps to 1.
        // The leading MVI at 0 hides the halt word at 1 behind its immediate.
        load_word(5'd0, 16'h0041);
        load_word(5'd1, 16'h01C0);
        for (int a = 2; a < 31; a++) begin
            load_word(5'(a), rand_instr(3'($urandom_range(2, 6))));
        end
        load_word(5'd31, 16'h0078);
        run_program(2, 1'b0, 300);

        // Start/Load_we during WAIT are ignored; the rerun proves RAM[0] is intact.
        run_program(3, 1'b1, 300);
        chk("ram0_kept", tb_mem[0] == 16'h0041 ? 1 : 0, 1);
        run_program(1, 1'b0, 300);

        // Reset in the middle of WAIT, with Start and Load_we asserted alongside it.
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        chk("rst_pre_busy", Busy, 1);
        Reset     = 1'b0;
        Start     = 1'b1;
        Load_we   = 1'b1;
        Load_adr  = '0;
        Load_data = 16'hFFFF;
        tick();
        Reset   = 1'b1;
        Start   = 1'b0;
        Load_we = 1'b0;
        chk_idle("rst_mid");
        tick();
        chk_idle("rst_after");
        run_program(2, 1'b0, 300);

        // Randomized programs with random processor latency.
        for (int r = 0; r < 5; r++) begin
            load_random_program();
            run_program($urandom_range(1, 4), 1'b0, 300);
        end

        // Counter saturation: a program with no halt wraps forever.
        for (int a = 0; a < DEPTH; a++) begin
            load_word(5'(a), rand_instr(3'b000));
        end
        run_program(1, 1'b0, 260);
        chk("sat_cnt", Instr_count, 255);
        chk("sat_pc", PC, 260 % DEPTH);
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        chk_idle("sat_reset");

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
